usb_rx_bit_decoder: RTL and testbench
=====================================

# usb_rx_bit_decoder

Front end of the USB full-speed receive datapath. It recovers bit timing from the D+/D- lines and NRZI-decodes each bit. It also detects stuffed bits and EOP, then drives the receive shift register with `d_orig`, `shift_enable` and `stuff_bit`. It also raises `byte_done` to the receiver control unit when a full data byte has landed in the shift register.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 8: system clocks per USB bit. Must be even and ≥ 4.
- `SAMPLE_PT`, default `CLKS_PER_BIT/2 - 1`: bit-counter value at which the line is sampled.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `d_plus`  in  1  D+ line.
- `d_minus`  in  1  D- line.
- `rcving`  in  1  high while the control unit is receiving a packet.
- `d_orig`  out  1  NRZI-decoded bit. Valid while `shift_enable` is high, held otherwise.
- `shift_enable`  out  1  one-cycle strobe per sampled bit, stuffed bits included.
- `stuff_bit`  out  1  high together with `shift_enable` when the sampled bit is a stuffed bit.
- `byte_done`  out  1  one-cycle pulse after the 8th non-stuff bit of a byte.
- `eop`  out  1  one-cycle pulse when SE0 (D+ = D- = 0) is sampled.
- `stuff_err`  out  1  one-cycle pulse when a stuffed-bit slot decodes as 1.

## Operation
- Reset values: `d_orig`=1, `shift_enable`=0, `stuff_bit`=0, `byte_done`=0, `eop`=0, `stuff_err`=0. Internal state on reset: `bit_cnt`=0, `ones_cnt`=0, `byte_cnt`=0, previous-sample register=1 (idle J).
- **Edge tracking.** `d_q` holds the previous-cycle `d_plus`. `edge` = (`d_plus` != `d_q`).
- **Bit counter.** `bit_cnt` loads 0 when `rcving`=0 or `edge`=1. Otherwise it increments, wrapping from `CLKS_PER_BIT-1` to 0.
- **Sample condition.** A sample occurs when `rcving`=1 and `bit_cnt`==`SAMPLE_PT`.
- **SE0 at sample.** `eop` pulses. No `shift_enable`. `ones_cnt` and `byte_cnt` clear. Previous-sample register sets to 1.
- **Normal sample.** Decoded bit = 1 if `d_plus` equals the previous-sample register, else 0. The previous-sample register then takes `d_plus`.
- **Stuffed-bit slot** (`ones_cnt`==6):
  - `shift_enable`=1 and `stuff_bit`=1.
  - `ones_cnt` clears; `byte_cnt` is unchanged.
  - If the decoded bit is 1, `stuff_err` pulses.
- **Other samples:**
  - `shift_enable`=1, `stuff_bit`=0, `d_orig`=decoded bit.
  - `ones_cnt` increments on 1 and clears on 0.
  - `byte_cnt` increments mod 8; the wrap 7→0 schedules `byte_done`.
- **`rcving` falling.** Takes effect next cycle: counters clear, previous-sample register sets to 1, pending pulses are dropped.
- **Reset mid-packet.** All state returns to reset values at the next edge and no partial `byte_done` is issued.

## Timing
- All outputs are registered.
- **Sample timing.** An input transition first clocked at edge t gives a sample at edge t+`SAMPLE_PT`+1. For the default parameters this is t+4, and the outputs are high during the cycle after that edge.
- **Without further edges,** subsequent samples follow every `CLKS_PER_BIT` cycles.
- **`byte_done`** is asserted exactly one cycle after the `shift_enable` cycle of the 8th data bit. The shift register output is therefore complete when `byte_done` is seen.
- **Pulse widths.** `shift_enable`, `eop`, `stuff_err` and `byte_done` are never high for two consecutive cycles.
- **Simultaneous events.** `edge` coinciding with `bit_cnt`==`SAMPLE_PT`: the sample is taken using the current `d_plus`, and the counter reloads 0.

## Configuration
- **`USB_RX_SYNC_EN` defined:** `d_plus` and `d_minus` pass through a 2-flop synchronizer, reset to 1 and 0 respectively, before any other logic. All latencies grow by 2 cycles.
- **`USB_RX_SYNC_EN` undefined:** inputs are used directly and must already be synchronous to `clk`.

## Test plan
All scenarios use default parameters with `USB_RX_SYNC_EN` undefined.
- **Reset.** Hold `rst`=1 for 3 cycles with lines toggling → all outputs at reset values; no `shift_enable` for 16 cycles after `rst`=0 while `rcving`=0.
- **Sync byte.** Drive NRZI pattern for 0x80 (sent LSB first: 0,0,0,0,0,0,0,1), 8 clocks per bit → 8 `shift_enable` pulses spaced 8 cycles apart, `d_orig` sequence 0,0,0,0,0,0,0,1, first strobe 4 cycles after the first transition, `byte_done` 1 cycle after the 8th strobe.
- **Bit stuffing.** Send byte 0xFF with a stuffed 0 after the 6th one → 9 strobes; strobe 7 has `stuff_bit`=1; `byte_done` follows strobe 9; no `stuff_err`.
- **Stuff error.** Seven consecutive decoded 1s → 7th strobe has `stuff_bit`=1 and `stuff_err` pulses for 1 cycle.
- **EOP.** Drive SE0 for 2 bit times after a byte → exactly one `eop` pulse, no `shift_enable` during SE0, `byte_cnt` cleared (next byte needs 8 strobes).
- **Abort.** Deassert `rcving` after 5 bits, then reassert and send 0x80 → no `byte_done` for the partial byte; the following byte decodes correctly.

Source files
------------

// File: rtl/usb_rx_bit_decoder.sv
// USB full-speed receive front end: bit-timing recovery, NRZI decode, bit-stuff and EOP detection.
// Define USB_RX_SYNC_EN to pass d_plus/d_minus through a 2-flop synchronizer (adds 2 cycles of latency).
module usb_rx_bit_decoder #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_PT    = CLKS_PER_BIT / 2 - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus,
  input  logic d_minus,
  input  logic rcving,
  output logic d_orig,
  output logic shift_enable,
  output logic stuff_bit,
  output logic byte_done,
  output logic eop,
  output logic stuff_err
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic          dp;
  logic          dm;
  logic          d_q;
  logic          prev_s;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    ones_cnt;
  logic [2:0]    byte_cnt;
  logic          byte_pend;
  logic          edge_det;
  logic          sample;
  logic          se0;
  logic          decoded;

`ifdef USB_RX_SYNC_EN
  logic [1:0] dp_sync;
  logic [1:0] dm_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_sync <= '1;
      dm_sync <= '0;
    end else begin
      dp_sync <= {dp_sync[0], d_plus};
      dm_sync <= {dm_sync[0], d_minus};
    end
  end

  assign dp = dp_sync[1];
  assign dm = dm_sync[1];
`else
  assign dp = d_plus;
  assign dm = d_minus;
`endif

  assign edge_det = (dp != d_q);
  assign sample   = rcving && (bit_cnt == CW'(SAMPLE_PT));
  assign se0      = !dp && !dm;
  assign decoded  = (dp == prev_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q          <= 1'b1;
      prev_s       <= 1'b1;
      bit_cnt      <= '0;
      ones_cnt     <= '0;
      byte_cnt     <= '0;
      byte_pend    <= 1'b0;
      d_orig       <= 1'b1;
      shift_enable <= 1'b0;
      stuff_bit    <= 1'b0;
      byte_done    <= 1'b0;
      eop          <= 1'b0;
      stuff_err    <= 1'b0;
    end else begin
      d_q          <= dp;
      shift_enable <= 1'b0;
      stuff_bit    <= 1'b0;
      eop          <= 1'b0;
      stuff_err    <= 1'b0;
      byte_pend    <= 1'b0;
      byte_done    <= byte_pend;

      // Any line transition re-centres the sampling point on the new bit.
      if (!rcving || edge_det || bit_cnt == CW'(CLKS_PER_BIT - 1))
        bit_cnt <= '0;
      else
        bit_cnt <= bit_cnt + 1'b1;

      if (!rcving) begin
        ones_cnt  <= '0;
        byte_cnt  <= '0;
        prev_s    <= 1'b1;
        byte_done <= 1'b0;
      end else if (sample) begin
        if (se0) begin
          eop      <= 1'b1;
          ones_cnt <= '0;
          byte_cnt <= '0;
          prev_s   <= 1'b1;
        end else begin
          prev_s       <= dp;
          shift_enable <= 1'b1;
          d_orig       <= decoded;
          if (ones_cnt == 3'd6) begin
            // Stuffed slot: must be a 0; it never counts toward the byte.
            stuff_bit <= 1'b1;
            stuff_err <= decoded;
            ones_cnt  <= '0;
          end else begin
            ones_cnt  <= decoded ? ones_cnt + 3'd1 : 3'd0;
            byte_cnt  <= byte_cnt + 3'd1;
            byte_pend <= (byte_cnt == 3'd7);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Directed bench for usb_rx_bit_decoder: per-bit-slot vector table plus hand-written reset/EOP sequences.
module tb_usb_rx_bit_decoder;

  logic clk = 1'b0;
  logic rst;
  logic d_plus;
  logic d_minus;
  logic rcving;
  logic d_orig;
  logic shift_enable;
  logic stuff_bit;
  logic byte_done;
  logic eop;
  logic stuff_err;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  usb_rx_bit_decoder #(
    .CLKS_PER_BIT(8),
    .SAMPLE_PT(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .d_plus       (d_plus),
    .d_minus      (d_minus),
    .rcving       (rcving),
    .d_orig       (d_orig),
    .shift_enable (shift_enable),
    .stuff_bit    (stuff_bit),
    .byte_done    (byte_done),
    .eop          (eop),
    .stuff_err    (stuff_err)
  );

  // One record per 8-clock bit slot: line levels, rcving, and expected strobe contents.
  // Sample pulses are expected 4 clocks into the slot, byte_done one clock later.
  typedef struct {
    logic dp, dm, rcv;
    logic se, sb, dor, bd, ep, serr;
  } vec_t;

  vec_t rows[$];

  function automatic vec_t v(input logic dp, input logic dm, input logic rcv,
                             input logic se, input logic sb, input logic dor,
                             input logic bd, input logic ep, input logic serr);
    vec_t r;
    r.dp = dp; r.dm = dm; r.rcv = rcv;
    r.se = se; r.sb = sb; r.dor = dor; r.bd = bd; r.ep = ep; r.serr = serr;
    return r;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, ".d_orig"}, d_orig, 1'b1);
    check({name, ".shift_enable"}, shift_enable, 1'b0);
    check({name, ".stuff_bit"}, stuff_bit, 1'b0);
    check({name, ".byte_done"}, byte_done, 1'b0);
    check({name, ".eop"}, eop, 1'b0);
    check({name, ".stuff_err"}, stuff_err, 1'b0);
  endtask

  task automatic apply_row(input int i);
    vec_t r;
    r = rows[i];
    d_plus  = r.dp;
    d_minus = r.dm;
    rcving  = r.rcv;
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("row%0d.c%0d.shift_enable", i, c), shift_enable, (c == 4) && r.se);
      check($sformatf("row%0d.c%0d.stuff_bit", i, c), stuff_bit, (c == 4) && r.sb);
      check($sformatf("row%0d.c%0d.eop", i, c), eop, (c == 4) && r.ep);
      check($sformatf("row%0d.c%0d.stuff_err", i, c), stuff_err, (c == 4) && r.serr);
      check($sformatf("row%0d.c%0d.byte_done", i, c), byte_done, (c == 5) && r.bd);
      if (c == 4 && r.se && !r.sb)
        check($sformatf("row%0d.d_orig", i), d_orig, r.dor);
    end
  endtask

  task automatic apply_rows(input int first, input int last);
    for (int i = first; i <= last; i++) apply_row(i);
  endtask

  initial begin
    int eop_n;
    int eop_at;

    rst     = 1'b1;
    rcving  = 1'b1;
    d_plus  = 1'b1;
    d_minus = 1'b0;

    // Sync byte 0x80: NRZI K,J,K,J,K,J,K,K from idle J -> 0,0,0,0,0,0,0,1 (rows 0-7)
    rows.push_back(v(0,1,1, 1,0,0, 0,0,0));
    rows.push_back(v(1,0,1, 1,0,0, 0,0,0));
    rows.push_back(v(0,1,1, 1,0,0, 0,0,0));
    rows.push_back(v(1,0,1, 1,0,0, 0,0,0));
    rows.push_back(v(0,1,1, 1,0,0, 0,0,0));
    rows.push_back(v(1,0,1, 1,0,0, 0,0,0));
    rows.push_back(v(0,1,1, 1,0,0, 0,0,0));
    rows.push_back(v(0,1,1, 1,0,1, 1,0,0));
    // Partial byte 1,0,1 then one SE0 slot (rows 8-11)
    rows.push_back(v(0,1,1, 1,0,1, 0,0,0));
    rows.push_back(v(1,0,1, 1,0,0, 0,0,0));
    rows.push_back(v(1,0,1, 1,0,1, 0,0,0));
    rows.push_back(v(0,0,1, 0,0,0, 0,1,0));
    // 0xFF with stuffed 0 after the sixth 1; byte_cnt restarted by the SE0 (rows 12-20)
    for (int k = 0; k < 6; k++) rows.push_back(v(1,0,1, 1,0,1, 0,0,0));
    rows.push_back(v(0,1,1, 1,1,0, 0,0,0));
    rows.push_back(v(0,1,1, 1,0,1, 0,0,0));
    rows.push_back(v(0,1,1, 1,0,1, 1,0,0));
    // A 0, then seven 1s: seventh lands in the stuff slot as 1 (rows 21-28)
    rows.push_back(v(1,0,1, 1,0,0, 0,0,0));
    for (int k = 0; k < 6; k++) rows.push_back(v(1,0,1, 1,0,1, 0,0,0));
    rows.push_back(v(1,0,1, 1,1,1, 0,0,1));
    // Abort: rcving low, 5 bits, rcving low, then 0x80 again (rows 29-43)
    rows.push_back(v(1,0,0, 0,0,0, 0,0,0));
    rows.push_back(v(0,1,1, 1,0,0, 0,0,0));
    rows.push_back(v(1,0,1, 1,0,0, 0,0,0));
    rows.push_back(v(0,1,1, 1,0,0, 0,0,0));
    rows.push_back(v(1,0,1, 1,0,0, 0,0,0));
    rows.push_back(v(0,1,1, 1,0,0, 0,0,0));
    rows.push_back(v(1,0,0, 0,0,0, 0,0,0));
    for (int k = 0; k < 8; k++) rows.push_back(rows[k]);

    // Reset held with lines toggling
    for (int i = 0; i < 3; i++) begin
      d_plus  = (i % 2 == 1);
      d_minus = ~d_plus;
      tick();
      check_reset_vals($sformatf("reset%0d", i));
    end

    // Idle after reset with rcving low: no strobes even though lines toggle
    rst    = 1'b0;
    rcving = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d_plus  = (i % 2 == 1);
      d_minus = ~d_plus;
      tick();
      check($sformatf("idle%0d.shift_enable", i), shift_enable, 1'b0);
      check($sformatf("idle%0d.eop", i), eop, 1'b0);
    end

    apply_rows(0, rows.size() - 1);

    // EOP of two bit times; rcving dropped the cycle after eop, as the control unit does
    apply_rows(8, 10);
    d_plus  = 1'b0;
    d_minus = 1'b0;
    eop_n   = 0;
    eop_at  = -1;
    for (int c = 0; c < 16; c++) begin
      tick();
      check($sformatf("se0_c%0d.shift_enable", c), shift_enable, 1'b0);
      if (eop === 1'b1) begin
        eop_n++;
        if (eop_at < 0) eop_at = c;
        rcving = 1'b0;
      end
    end
    check_int("eop_count", eop_n, 1);
    check_int("eop_position", eop_at, 4);

    d_plus  = 1'b1;
    d_minus = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("post_eop%0d.shift_enable", c), shift_enable, 1'b0);
      check($sformatf("post_eop%0d.byte_done", c), byte_done, 1'b0);
    end

    // Reset mid-packet with rcving still high; the next byte must restart from zero
    apply_rows(0, 5);
    rst     = 1'b1;
    rcving  = 1'b1;
    d_plus  = 1'b0;
    d_minus = 1'b1;
    tick();
    check_reset_vals("midreset0");
    d_plus  = 1'b1;
    d_minus = 1'b0;
    tick();
    check_reset_vals("midreset1");
    rst = 1'b0;
    apply_rows(0, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
